// File: rtl/onehot_ring_sequencer_pkg.sv
// Shared types and helpers for the one-hot ring sequencer.
// Provides the FSM state enum, the default ring width and a one-hot encoder.
package onehot_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } onehot_state_t;

  localparam int ONEHOT_W = 4;

  // Callers truncate the result to their ring width, so widths up to 32 are supported.
  function automatic logic [31:0] onehot_of(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/onehot_ring_sequencer.sv
// Registered one-hot ring counter with direction control, direct load and wrap pulse.
// Optional idle/zero state (S = 0, clear input honoured) when ONEHOT_ZERO_STATE_EN is defined.
module onehot_ring_sequencer
  import onehot_pkg::*;
#(
  parameter int WIDTH = ONEHOT_W,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 load,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic                 clear,
  output logic [WIDTH-1:0]     S,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid,
  output logic                 wrap,
  output logic                 load_err,
  output onehot_state_t        dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] BIT_LO   = WIDTH'(1);
  localparam logic [WIDTH-1:0] BIT_HI   = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ONEHOT_ZERO_STATE_EN
  localparam onehot_state_t    RST_STATE = ST_IDLE;
  localparam logic [WIDTH-1:0] RST_S     = '0;
`else
  localparam onehot_state_t    RST_STATE = ST_RUN;
  localparam logic [WIDTH-1:0] RST_S     = BIT_LO;
`endif

  onehot_state_t    r_state;
  logic [WIDTH-1:0] r_s;
  logic [IDX_W-1:0] r_idx;
  logic             r_wrap;
  logic             r_load_err;

  onehot_state_t    w_nxt_state;
  logic [WIDTH-1:0] w_nxt_s;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_nxt_wrap;
  logic             w_nxt_load_err;
  logic             w_load_ok;
  logic [WIDTH-1:0] w_load_vec;

  // Out-of-range indices only exist when WIDTH is not a power of two.
  assign w_load_ok  = (32'(load_idx) < 32'(WIDTH));
  assign w_load_vec = WIDTH'(onehot_of(32'(load_idx)));

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_s        = r_s;
    w_nxt_idx      = r_idx;
    w_nxt_wrap     = 1'b0;
    w_nxt_load_err = 1'b0;
    if (load) begin
      if (w_load_ok) begin
        w_nxt_state = ST_RUN;
        w_nxt_s     = w_load_vec;
        w_nxt_idx   = load_idx;
      end else begin
        w_nxt_load_err = 1'b1;
      end
    end
`ifdef ONEHOT_ZERO_STATE_EN
    else if (clear) begin
      w_nxt_state = ST_IDLE;
      w_nxt_s     = '0;
      w_nxt_idx   = '0;
    end else if (en && (r_state == ST_IDLE)) begin
      w_nxt_state = ST_RUN;
      w_nxt_s     = dir ? BIT_HI : BIT_LO;
      w_nxt_idx   = dir ? LAST_IDX : '0;
    end
`endif
    else if (en) begin
      if (!dir) begin
        w_nxt_s    = {r_s[WIDTH-2:0], r_s[WIDTH-1]};
        w_nxt_idx  = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        w_nxt_wrap = (r_idx == LAST_IDX);
      end else begin
        w_nxt_s    = {r_s[0], r_s[WIDTH-1:1]};
        w_nxt_idx  = (r_idx == '0) ? LAST_IDX : r_idx - 1'b1;
        w_nxt_wrap = (r_idx == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_s        <= RST_S;
      r_idx      <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_s        <= w_nxt_s;
      r_idx      <= w_nxt_idx;
      r_wrap     <= w_nxt_wrap;
      r_load_err <= w_nxt_load_err;
    end
  end

  assign S         = r_s;
  assign idx       = r_idx;
  assign wrap      = r_wrap;
  assign load_err  = r_load_err;
  assign dbg_state = r_state;

`ifdef ONEHOT_ZERO_STATE_EN
  assign valid = (r_state == ST_RUN);
`else
  // Without the idle state the ring is always populated; clear has no effect.
  logic w_unused_clear;
  assign w_unused_clear = clear;
  assign valid          = 1'b1;
`endif

endmodule

// File: tb/tb_onehot_ring_sequencer.sv
// Directed and model-checked bench for onehot_ring_sequencer (WIDTH=4 and WIDTH=5 instances).
// Honours ONEHOT_ZERO_STATE_EN for reset and clear expectations.
module tb_onehot_ring_sequencer;
  import onehot_pkg::*;

  logic clk;

  logic rst4, en4, dir4, load4, clear4;
  logic [1:0] lidx4;
  logic [3:0] s4;
  logic [1:0] idx4;
  logic v4, w4, e4;
  onehot_state_t st4;

  logic rst5, en5, dir5, load5, clear5;
  logic [2:0] lidx5;
  logic [4:0] s5;
  logic [2:0] idx5;
  logic v5, w5, e5;
  onehot_state_t st5;

  int n_checks;
  int n_pass;

`ifdef ONEHOT_ZERO_STATE_EN
  localparam logic [3:0]    RST_S4 = 4'b0000;
  localparam logic [4:0]    RST_S5 = 5'b00000;
  localparam logic          RST_V  = 1'b0;
  localparam onehot_state_t RST_ST = ST_IDLE;
`else
  localparam logic [3:0]    RST_S4 = 4'b0001;
  localparam logic [4:0]    RST_S5 = 5'b00001;
  localparam logic          RST_V  = 1'b1;
  localparam onehot_state_t RST_ST = ST_RUN;
`endif

  onehot_ring_sequencer #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en4), .dir(dir4), .load(load4), .load_idx(lidx4),
    .clear(clear4), .S(s4), .idx(idx4), .valid(v4), .wrap(w4), .load_err(e4),
    .dbg_state(st4)
  );

  onehot_ring_sequencer #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst5), .en(en5), .dir(dir5), .load(load5), .load_idx(lidx5),
    .clear(clear5), .S(s5), .idx(idx5), .valid(v5), .wrap(w5), .load_err(e5),
    .dbg_state(st5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic det_zero(input logic [4:0] s);
    return (s == 5'd0);
  endfunction

  function automatic logic det_valid(input logic [4:0] s);
    return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst4 = 0; en4 = 0; dir4 = 0; load4 = 0; clear4 = 0; lidx4 = '0;
    rst5 = 0; en5 = 0; dir5 = 0; load5 = 0; clear5 = 0; lidx5 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst4 = 1; rst5 = 1; en4 = 1; en5 = 1; load4 = 1; lidx4 = 2'd3;
    tick();
    idle_inputs();
    n_checks++;
    if ({s4, idx4, v4, w4, e4, st4} !== {RST_S4, 2'd0, RST_V, 1'b0, 1'b0, RST_ST})
      $display("FAIL reset4 got S=%b idx=%0d v=%b w=%b e=%b st=%0d exp S=%b idx=0 v=%b",
               s4, idx4, v4, w4, e4, st4, RST_S4, RST_V);
    else n_pass++;
    n_checks++;
    if ({s5, idx5, v5, w5, e5} !== {RST_S5, 3'd0, RST_V, 1'b0, 1'b0})
      $display("FAIL reset5 got S=%b idx=%0d v=%b w=%b e=%b exp S=%b idx=0 v=%b",
               s5, idx5, v5, w5, e5, RST_S5, RST_V);
    else n_pass++;
  endtask

  task automatic test_rotate_up();
    logic [3:0] exp_s [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] exp_i [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       exp_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    idle_inputs();
    load4 = 1; lidx4 = 2'd0;
    tick();
    idle_inputs();
    n_checks++;
    if ({s4, idx4, v4} !== {4'b0001, 2'd0, 1'b1})
      $display("FAIL load0 got S=%b idx=%0d v=%b exp S=0001 idx=0 v=1", s4, idx4, v4);
    else n_pass++;
    en4 = 1; dir4 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({s4, idx4, w4, e4} !== {exp_s[i], exp_i[i], exp_w[i], 1'b0})
        $display("FAIL rot_up[%0d] got S=%b idx=%0d w=%b e=%b exp S=%b idx=%0d w=%b e=0",
                 i, s4, idx4, w4, e4, exp_s[i], exp_i[i], exp_w[i]);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_rotate_down();
    idle_inputs();
    load4 = 1; lidx4 = 2'd0;
    tick();
    idle_inputs();
    en4 = 1; dir4 = 1;
    tick();
    n_checks++;
    if ({s4, idx4, w4} !== {4'b1000, 2'd3, 1'b1})
      $display("FAIL rot_dn_wrap got S=%b idx=%0d w=%b exp S=1000 idx=3 w=1", s4, idx4, w4);
    else n_pass++;
    tick();
    n_checks++;
    if ({s4, idx4, w4} !== {4'b0100, 2'd2, 1'b0})
      $display("FAIL rot_dn got S=%b idx=%0d w=%b exp S=0100 idx=2 w=0", s4, idx4, w4);
    else n_pass++;
    en4 = 0;
    tick();
    n_checks++;
    if ({s4, idx4, w4, v4} !== {4'b0100, 2'd2, 1'b0, 1'b1})
      $display("FAIL hold got S=%b idx=%0d w=%b v=%b exp S=0100 idx=2 w=0 v=1", s4, idx4, w4, v4);
    else n_pass++;
    // Direction change on consecutive cycles
    en4 = 1; dir4 = 0;
    tick();
    dir4 = 1;
    tick();
    n_checks++;
    if ({s4, idx4, w4} !== {4'b0100, 2'd2, 1'b0})
      $display("FAIL dir_flip got S=%b idx=%0d w=%b exp S=0100 idx=2 w=0", s4, idx4, w4);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_load();
    idle_inputs();
    load4 = 1; lidx4 = 2'd1;
    tick();
    load4 = 1; lidx4 = 2'd2; en4 = 1; dir4 = 0;
    tick();
    n_checks++;
    if ({s4, idx4, w4, e4} !== {4'b0100, 2'd2, 1'b0, 1'b0})
      $display("FAIL load_over_en got S=%b idx=%0d w=%b e=%b exp S=0100 idx=2 w=0 e=0", s4, idx4, w4, e4);
    else n_pass++;
    load4 = 1; lidx4 = 2'd3; en4 = 0;
    tick();
    load4 = 1; lidx4 = 2'd0; en4 = 1; dir4 = 0;
    tick();
    n_checks++;
    if ({s4, idx4, w4} !== {4'b0001, 2'd0, 1'b0})
      $display("FAIL load_no_wrap got S=%b idx=%0d w=%b exp S=0001 idx=0 w=0", s4, idx4, w4);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_load_err();
    idle_inputs();
    load5 = 1; lidx5 = 3'd4;
    tick();
    n_checks++;
    if ({s5, idx5, v5, e5} !== {5'b10000, 3'd4, 1'b1, 1'b0})
      $display("FAIL load5_top got S=%b idx=%0d v=%b e=%b exp S=10000 idx=4 v=1 e=0", s5, idx5, v5, e5);
    else n_pass++;
    load5 = 1; lidx5 = 3'd6; en5 = 1; dir5 = 0;
    tick();
    n_checks++;
    if ({s5, idx5, w5, e5} !== {5'b10000, 3'd4, 1'b0, 1'b1})
      $display("FAIL load_err got S=%b idx=%0d w=%b e=%b exp S=10000 idx=4 w=0 e=1", s5, idx5, w5, e5);
    else n_pass++;
    load5 = 0;
    tick();
    n_checks++;
    if ({s5, idx5, w5, e5} !== {5'b00001, 3'd0, 1'b1, 1'b0})
      $display("FAIL wrap5 got S=%b idx=%0d w=%b e=%b exp S=00001 idx=0 w=1 e=0", s5, idx5, w5, e5);
    else n_pass++;
    load5 = 1; lidx5 = 3'd5; en5 = 0;
    tick();
    load5 = 0;
    tick();
    n_checks++;
    if ({s5, idx5, e5} !== {5'b00001, 3'd0, 1'b0})
      $display("FAIL load_err_pulse got S=%b idx=%0d e=%b exp S=00001 idx=0 e=0", s5, idx5, e5);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_clear();
    idle_inputs();
    load4 = 1; lidx4 = 2'd2;
    tick();
    idle_inputs();
    clear4 = 1;
    tick();
`ifdef ONEHOT_ZERO_STATE_EN
    n_checks++;
    if ({det_zero({1'b0, s4}), s4, idx4, v4, w4, st4} !== {1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, ST_IDLE})
      $display("FAIL clear got S=%b idx=%0d v=%b w=%b st=%0d exp S=0000 idx=0 v=0 idle", s4, idx4, v4, w4, st4);
    else n_pass++;
    clear4 = 0;
    tick();
    n_checks++;
    if ({s4, v4} !== {4'b0000, 1'b0})
      $display("FAIL idle_hold got S=%b v=%b exp S=0000 v=0", s4, v4);
    else n_pass++;
    en4 = 1; dir4 = 1;
    tick();
    n_checks++;
    if ({s4, idx4, v4, w4} !== {4'b1000, 2'd3, 1'b1, 1'b0})
      $display("FAIL idle_exit_dn got S=%b idx=%0d v=%b w=%b exp S=1000 idx=3 v=1 w=0", s4, idx4, v4, w4);
    else n_pass++;
    clear4 = 1; load4 = 1; lidx4 = 2'd1;
    tick();
    n_checks++;
    if ({s4, idx4, v4} !== {4'b0010, 2'd1, 1'b1})
      $display("FAIL load_over_clear got S=%b idx=%0d v=%b exp S=0010 idx=1 v=1", s4, idx4, v4);
    else n_pass++;
`else
    n_checks++;
    if ({s4, idx4, v4} !== {4'b0100, 2'd2, 1'b1})
      $display("FAIL clear_ignored got S=%b idx=%0d v=%b exp S=0100 idx=2 v=1", s4, idx4, v4);
    else n_pass++;
    en4 = 1; dir4 = 0;
    tick();
    tick();
    n_checks++;
    if ({s4, idx4, w4} !== {4'b0001, 2'd0, 1'b1})
      $display("FAIL clear_en got S=%b idx=%0d w=%b exp S=0001 idx=0 w=1", s4, idx4, w4);
    else n_pass++;
`endif
    idle_inputs();
  endtask

  task automatic test_reset_midrun();
    idle_inputs();
    load4 = 1; lidx4 = 2'd2;
    tick();
    idle_inputs();
    en4 = 1;
    tick();
    rst4 = 1; load4 = 1; lidx4 = 2'd3; clear4 = 1;
    tick();
    idle_inputs();
    n_checks++;
    if ({s4, idx4, v4, w4, e4} !== {RST_S4, 2'd0, RST_V, 1'b0, 1'b0})
      $display("FAIL rst_midrun got S=%b idx=%0d v=%b w=%b e=%b exp S=%b idx=0 v=%b",
               s4, idx4, v4, w4, e4, RST_S4, RST_V);
    else n_pass++;
  endtask

  task automatic test_random();
    logic       m_run;
    int         m_idx;
    logic       m_wrap, m_err;
    logic [4:0] exp_s;
    idle_inputs();
    m_run = 0; m_idx = 0;
    for (int i = 0; i < 1000; i++) begin
      rst5   = (i == 0) || (i == 400) || (i == 777);
      load5  = ($urandom_range(0, 7) == 0);
      lidx5  = 3'($urandom_range(0, 7));
      clear5 = ($urandom_range(0, 9) == 0);
      en5    = ($urandom_range(0, 3) != 0);
      dir5   = 1'($urandom_range(0, 1));
      m_wrap = 0; m_err = 0;
      if (rst5) begin
        m_run = RST_V; m_idx = 0;
      end else if (load5) begin
        if (lidx5 < 3'd5) begin m_run = 1; m_idx = int'(lidx5); end
        else m_err = 1;
      end
`ifdef ONEHOT_ZERO_STATE_EN
      else if (clear5) begin m_run = 0; m_idx = 0; end
`endif
      else if (en5) begin
        if (!m_run) begin
          m_run = 1; m_idx = dir5 ? 4 : 0;
        end else if (!dir5) begin
          m_wrap = (m_idx == 4); m_idx = (m_idx == 4) ? 0 : m_idx + 1;
        end else begin
          m_wrap = (m_idx == 0); m_idx = (m_idx == 0) ? 4 : m_idx - 1;
        end
      end
      tick();
      exp_s = m_run ? (5'b00001 << m_idx) : 5'b00000;
      n_checks++;
      if ({s5, idx5, v5, w5, e5} !== {exp_s, 3'(m_idx), m_run, m_wrap, m_err})
        $display("FAIL rand[%0d] got S=%b idx=%0d v=%b w=%b e=%b exp S=%b idx=%0d v=%b w=%b e=%b",
                 i, s5, idx5, v5, w5, e5, exp_s, m_idx, m_run, m_wrap, m_err);
      else n_pass++;
      n_checks++;
      if ((m_run ? det_valid(s5) : det_zero(s5)) !== 1'b1)
        $display("FAIL rand_det[%0d] got S=%b run=%b exp one-hot when running, zero when idle",
                 i, s5, m_run);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    tick();
    test_reset();
    test_rotate_up();
    test_rotate_down();
    test_load();
    test_load_err();
    test_clear();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
